// File: rtl/nios2_debug_scan_slave_multi.sv
// Nios II debug scan slave: samples virtual-JTAG pins into clk, shifts a DR_W scan register and issues
// held per-channel take_action / take_no_action requests. Optional build macro: NIOS2_DEBUG_SCAN_PARITY_EN.
module nios2_debug_scan_slave_multi #(
  parameter int IR_W = 2,
  parameter int DR_W = 38,
  parameter int SYNC = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tck,
  input  logic                              tdi,
  input  logic [IR_W-1:0]                   ir_in,
  input  logic                              vs_cdr,
  input  logic                              vs_sdr,
  input  logic                              vs_udr,
  input  logic                              vs_uir,
  input  logic [(2**IR_W)*(DR_W-2)-1:0]     capture_data,
  input  logic                              action_ready,
  output logic                              tdo,
  output logic [DR_W-1:0]                   jdo,
  output logic [(2**IR_W)-1:0]              take_action,
  output logic [(2**IR_W)-1:0]              take_no_action,
  output logic                              overrun
);
  localparam int NCH = 2 ** IR_W;
  localparam int CW  = DR_W - 2;

  logic [SYNC-1:0] tck_sync_q, tdi_sync_q, cdr_sync_q, sdr_sync_q, udr_sync_q, uir_sync_q;
  logic            tck_prev_q, udr_prev_q, uir_prev_q;
  logic [DR_W-1:0] sr_q, sr_d, jdo_q, jdo_d;
  logic [NCH-1:0]  act_q, act_d, noact_q, noact_d;
  logic            ovr_q, ovr_d, tdo_q, tdo_d;
  logic            tck_s, tdi_s, cdr_s, sdr_s, udr_s, uir_s;
  logic            tck_rise_s, udr_rise_s, uir_rise_s, pending_s;
  logic [CW-1:0]   cap_words_s [NCH];
  logic [CW-1:0]   cap_word_s;
  logic [NCH-1:0]  ch_onehot_s;

  // Multi-flop synchronisers plus previous-value flops for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tck_sync_q <= '0;
      tdi_sync_q <= '0;
      cdr_sync_q <= '0;
      sdr_sync_q <= '0;
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      tck_prev_q <= 1'b0;
      udr_prev_q <= 1'b0;
      uir_prev_q <= 1'b0;
    end else begin
      tck_sync_q <= {tck_sync_q[SYNC-2:0], tck};
      tdi_sync_q <= {tdi_sync_q[SYNC-2:0], tdi};
      cdr_sync_q <= {cdr_sync_q[SYNC-2:0], vs_cdr};
      sdr_sync_q <= {sdr_sync_q[SYNC-2:0], vs_sdr};
      udr_sync_q <= {udr_sync_q[SYNC-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC-2:0], vs_uir};
      tck_prev_q <= tck_s;
      udr_prev_q <= udr_s;
      uir_prev_q <= uir_s;
    end
  end

  assign tck_s      = tck_sync_q[SYNC-1];
  assign tdi_s      = tdi_sync_q[SYNC-1];
  assign cdr_s      = cdr_sync_q[SYNC-1];
  assign sdr_s      = sdr_sync_q[SYNC-1];
  assign udr_s      = udr_sync_q[SYNC-1];
  assign uir_s      = uir_sync_q[SYNC-1];
  assign tck_rise_s = tck_s & ~tck_prev_q;
  assign udr_rise_s = udr_s & ~udr_prev_q;
  assign uir_rise_s = uir_s & ~uir_prev_q;
  assign pending_s  = |(act_q | noact_q);
  assign ch_onehot_s = {{(NCH-1){1'b0}}, 1'b1} << ir_in;

  for (genvar k = 0; k < NCH; k++) begin : g_cap
    assign cap_words_s[k] = capture_data[k*CW +: CW];
  end
  assign cap_word_s = cap_words_s[ir_in];

  // Scan register, tdo and request/overrun next-state
  always_comb begin
    sr_d    = sr_q;
    tdo_d   = tdo_q;
    jdo_d   = jdo_q;
    act_d   = act_q;
    noact_d = noact_q;
    ovr_d   = ovr_q;

    if (uir_rise_s) begin
      sr_d = '0;
    end else if (tck_rise_s && cdr_s) begin
      sr_d = {ovr_q, pending_s, cap_word_s};
    end else if (tck_rise_s && sdr_s) begin
      sr_d  = {tdi_s, sr_q[DR_W-1:1]};
      tdo_d = sr_q[0];
    end else begin
      sr_d = sr_q;
    end

    if (pending_s && action_ready) begin
      act_d   = '0;
      noact_d = '0;
    end else begin
      act_d   = act_q;
      noact_d = noact_q;
    end

    // A request is only raised when none is pending, so the clear above never races it
    if (udr_rise_s) begin
`ifdef NIOS2_DEBUG_SCAN_PARITY_EN
      if (^sr_q) begin
        ovr_d = 1'b1;
      end else if (pending_s) begin
        jdo_d = sr_q;
        ovr_d = 1'b1;
      end else begin
        jdo_d = sr_q;
        ovr_d = 1'b0;
        if (sr_q[DR_W-1]) begin
          act_d = ch_onehot_s;
        end else begin
          noact_d = ch_onehot_s;
        end
      end
`else
      jdo_d = sr_q;
      if (pending_s) begin
        ovr_d = 1'b1;
      end else begin
        if (sr_q[DR_W-1]) begin
          act_d = ch_onehot_s;
        end else begin
          noact_d = ch_onehot_s;
        end
        if (sr_q[DR_W-2]) begin
          ovr_d = 1'b0;
        end else begin
          ovr_d = ovr_q;
        end
      end
`endif
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= '0;
      jdo_q   <= '0;
      act_q   <= '0;
      noact_q <= '0;
      ovr_q   <= 1'b0;
      tdo_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      jdo_q   <= jdo_d;
      act_q   <= act_d;
      noact_q <= noact_d;
      ovr_q   <= ovr_d;
      tdo_q   <= tdo_d;
    end
  end

  assign tdo            = tdo_q;
  assign jdo            = jdo_q;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_nios2_debug_scan_slave_multi.sv
// Self-checking bench for nios2_debug_scan_slave_multi: directed scenarios then randomized
// transactions against a transaction-level model (honours NIOS2_DEBUG_SCAN_PARITY_EN).
module tb_nios2_debug_scan_slave_multi;
  localparam int IR_W = 2;
  localparam int DR_W = 38;
  localparam int NCH  = 4;
  localparam int CW   = 36;

  logic clk = 1'b0;
  logic reset, tck, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir, action_ready;
  logic [IR_W-1:0]   ir_in;
  logic [NCH*CW-1:0] capture_data;
  logic              tdo, overrun;
  logic [DR_W-1:0]   jdo;
  logic [NCH-1:0]    take_action, take_no_action;

  nios2_debug_scan_slave_multi #(.IR_W(IR_W), .DR_W(DR_W), .SYNC(2)) dut (
    .clk(clk), .reset(reset), .tck(tck), .tdi(tdi), .ir_in(ir_in),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .capture_data(capture_data), .action_ready(action_ready),
    .tdo(tdo), .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // transaction-level reference state
  logic [DR_W-1:0] m_sr, m_jdo;
  int              m_req_ch;
  logic            m_req_act, m_ovr;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2*NCH-1:0] m_req_vec();
    logic [NCH-1:0] oh;
    oh = '0;
    if (m_req_ch < 0) return '0;
    oh[m_req_ch] = 1'b1;
    return m_req_act ? {oh, {NCH{1'b0}}} : {{NCH{1'b0}}, oh};
  endfunction

  task automatic model_reset();
    m_sr = '0; m_jdo = '0; m_req_ch = -1; m_req_act = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [2*NCH-1:0] ev;
    ev = m_req_vec();
    check_val({tag, "_jdo"}, 64'(jdo), 64'(m_jdo));
    check_val({tag, "_take_action"}, 64'(take_action), 64'(ev[2*NCH-1:NCH]));
    check_val({tag, "_take_no_action"}, 64'(take_no_action), 64'(ev[NCH-1:0]));
    check_val({tag, "_overrun"}, 64'(overrun), 64'(m_ovr));
  endtask

  task automatic tck_cycle(input logic bit_in);
    tdi = bit_in;
    clocks(4);
    tck = 1'b1;
    clocks(4);
    tck = 1'b0;
  endtask

  task automatic do_capture();
    logic [CW-1:0] w;
    vs_cdr = 1'b1;
    tck_cycle(1'b0);
    vs_cdr = 1'b0;
    w = capture_data[int'(ir_in)*CW +: CW];
    m_sr = {m_ovr, (m_req_ch >= 0), w};
  endtask

  task automatic do_shift(input int n, input logic [DR_W-1:0] data, output logic [DR_W-1:0] word);
    word = '0;
    vs_sdr = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic exp_bit;
      exp_bit = m_sr[0];
      tck_cycle(data[i]);
      m_sr = {data[i], m_sr[DR_W-1:1]};
      word[i] = tdo;
      check_val("tdo", 64'(tdo), 64'(exp_bit));
    end
    vs_sdr = 1'b0;
  endtask

  task automatic do_uir();
    vs_uir = 1'b1;
    clocks(4);
    vs_uir = 1'b0;
    clocks(2);
    m_sr = '0;
  endtask

  task automatic do_update(input logic ready);
    int hi;
    logic raised;
    logic [2*NCH-1:0] seen, ev;
    hi = 0; seen = '0; raised = 1'b0;
    action_ready = ready;
    clocks(1);
    if (ready) m_req_ch = -1;
    vs_udr = 1'b1;
    for (int c = 0; c < 8; c++) begin
      clocks(1);
      if ((take_action | take_no_action) != '0) begin
        hi++;
        seen = {take_action, take_no_action};
      end
    end
    vs_udr = 1'b0;
    clocks(2);
`ifdef NIOS2_DEBUG_SCAN_PARITY_EN
    if (^m_sr) m_ovr = 1'b1;
    else begin
      m_jdo = m_sr;
      if (m_req_ch >= 0) m_ovr = 1'b1;
      else begin
        m_req_ch = int'(ir_in); m_req_act = m_sr[DR_W-1]; raised = 1'b1; m_ovr = 1'b0;
      end
    end
`else
    m_jdo = m_sr;
    if (m_req_ch >= 0) m_ovr = 1'b1;
    else begin
      m_req_ch = int'(ir_in); m_req_act = m_sr[DR_W-1]; raised = 1'b1;
      if (m_sr[DR_W-2]) m_ovr = 1'b0;
    end
`endif
    ev = m_req_vec();
    if (ready) begin
      check_val("pulse_cycles", 64'(hi), raised ? 64'd1 : 64'd0);
      if (raised) check_val("pulse_vec", 64'(seen), 64'(ev));
      m_req_ch = -1;
      action_ready = 1'b0;
    end
    check_outputs("upd");
  endtask

  task automatic do_ack();
    action_ready = 1'b1;
    clocks(1);
    action_ready = 1'b0;
    clocks(1);
    m_req_ch = -1;
    check_outputs("ack");
  endtask

  initial begin
    logic [DR_W-1:0] word;
    logic [63:0] r;
    int hi;
    reset = 1'b1; tck = 1'b0; tdi = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0;
    vs_uir = 1'b0; action_ready = 1'b0; ir_in = '0; capture_data = '0;
    model_reset();
    clocks(3);
    check_outputs("reset");
    check_val("reset_tdo", 64'(tdo), 64'd0);
    reset = 1'b0;
    clocks(4);

    // 1: request pending, then reset in the middle of a shift
    ir_in = 2'd1;
    do_shift(DR_W, 38'h20_0000_0003, word);
    do_update(1'b0);
    vs_sdr = 1'b1; tdi = 1'b1;
    clocks(4);
    tck = 1'b1;
    clocks(2);
    reset = 1'b1;
    clocks(1);
    model_reset();
    check_outputs("rst_mid");
    check_val("rst_mid_tdo", 64'(tdo), 64'd0);
    tck = 1'b0; vs_sdr = 1'b0; tdi = 1'b0;
    clocks(2);
    reset = 1'b0;
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      clocks(1);
      if ((take_action | take_no_action) != '0) hi++;
    end
    check_val("rst_no_req", 64'(hi), 64'd0);

    // 2: capture channel 2 and shift it out
    ir_in = 2'd2;
    capture_data[2*CW +: CW] = 36'hA_5A5A_5A5A;
    do_capture();
    do_shift(DR_W, '0, word);
    check_val("cap_stream", 64'(word), 64'({2'b00, 36'hA_5A5A_5A5A}));

    // 3: take_action pulse on channel 1
    ir_in = 2'd1;
    do_shift(DR_W, 38'h20_0000_1234, word);
    do_update(1'b1);
    check_val("t3_jdo", 64'(jdo), 64'h20_0000_1234);

    // 4: two updates with no ready, overrun set, then acknowledge
    ir_in = 2'd3;
    do_shift(DR_W, 38'h00_0000_0003, word);
    do_update(1'b0);
    check_val("t4_hold", 64'(take_no_action), 64'(4'b1000));
    do_shift(DR_W, 38'h00_0000_0005, word);
    do_update(1'b0);
    check_val("t4_ovr", 64'(overrun), 64'd1);
    check_val("t4_jdo", 64'(jdo), 64'h00_0000_0005);
    do_ack();

    // 5: status bits on capture, then W1C of overrun
    do_capture();
    check_val("t5_status", 64'(m_sr[DR_W-1:DR_W-2]), 64'(2'b10));
    do_shift(DR_W, 38'h10_0000_0001, word);
    check_val("t5_status_out", 64'(word[DR_W-1:DR_W-2]), 64'(2'b10));
    do_update(1'b1);
    check_val("t5_ovr_clr", 64'(overrun), 64'd0);

`ifdef NIOS2_DEBUG_SCAN_PARITY_EN
    // 6: parity error leaves jdo alone and sets overrun
    do_shift(DR_W, 38'h00_0000_0001, word);
    do_update(1'b1);
    check_val("t6_jdo", 64'(jdo), 64'h10_0000_0001);
    check_val("t6_ovr", 64'(overrun), 64'd1);
`endif

    for (int t = 0; t < 40; t++) begin
      ir_in = IR_W'($urandom_range(0, NCH - 1));
      for (int k = 0; k < NCH; k++) begin
        r = {$urandom, $urandom};
        capture_data[k*CW +: CW] = r[CW-1:0];
      end
      if ($urandom_range(0, 1) == 1) do_capture();
      r = {$urandom, $urandom};
      do_shift($urandom_range(20, DR_W), r[DR_W-1:0], word);
      if ($urandom_range(0, 7) == 0) do_uir();
      do_update(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) do_ack();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
